// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter with terminal-count pulse and optional auto-reload.
// All bits update on the same clk edge, so count is safe to use as a divider/timer tap.
//
//  state | meaning
//  ------+-----------------------------------------------
//  IDLE  | out of reset, count holds, waiting for a load
//  RUN   | decrementing on each enabled cycle
//  DONE  | terminal count reached, count parked at 0
module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] reload_reg, reload_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            tc         <= tc_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        tc_nxt     = 1'b0;
        if (load) begin
            count_nxt  = load_val;
            reload_nxt = load_val;
            state_nxt  = (load_val != '0) ? RUN : DONE;
        end else if (state == RUN && en) begin
            if (count > ONE) begin
                count_nxt = count - ONE;
            end else if (count == ONE) begin
                count_nxt = '0;
                tc_nxt    = 1'b1;
                if (!auto_reload) begin
                    state_nxt = DONE;
                end
            end else if (auto_reload && reload_reg != '0) begin
                // count==0 is only reachable in RUN via auto-reload: this is the reload cycle
                count_nxt = reload_reg;
            end else begin
                state_nxt = DONE;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
Synchronous, loadable down counter. It is the counting-down, single-clock counterpart to the team's ripple up counter.
- Software or an FSM loads a start value; the block decrements on each enabled cycle.
- It signals terminal count, then stops or auto-reloads.
- Used as a programmable timer/divider where every bit must change on the same clk edge.

Parameters:
WIDTH, 4, counter and load value width in bits (minimum 2).

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset; sampled on clk rising edge.
load  input  1  load request; copies load_val into count and reload register.
load_val  input  WIDTH  start/reload value.
en  input  1  count enable; one decrement per clk cycle while high in RUN.
auto_reload  input  1  1: reload from reload register after reaching 0; 0: stop at 0.
count  output  WIDTH  current counter value (registered).
tc  output  1  terminal-count pulse (registered), high one cycle after count goes 1->0.
busy  output  1  high while in RUN.
done  output  1  high while in DONE.

Behaviour:
Reset:
- rst high at a clk edge gives count=0, reload_reg=0, state=IDLE, tc=0, busy=0, done=0.
- rst has priority over every other input and aborts a run in progress at that edge.

State machine (3 states):
- IDLE: count holds.
- RUN: decrementing.
- DONE: count=0, holding.
- busy = (state==RUN); done = (state==DONE). Both are decoded from the state register with no combinational path from inputs.

Priority per edge: rst > load > en.

Load, accepted in any state:
- count<=load_val and reload_reg<=load_val; tc<=0.
- Next state is RUN if load_val!=0, else DONE.
- A load on the same edge as a would-be terminal decrement wins: no tc, count takes load_val.

RUN with en=1:
- If count>1: count<=count-1, tc<=0.
- If count==1: count<=0, tc<=1.
  - auto_reload=1: stay in RUN.
  - auto_reload=0: go to DONE.
- If count==0 (only reachable via auto_reload):
  - auto_reload=1 and reload_reg!=0: count<=reload_reg, tc<=0, stay in RUN.
  - Otherwise: go to DONE with count held at 0.

RUN with en=0: count and state hold; tc<=0.

IDLE/DONE without load: count holds; en is ignored; tc<=0.

Arithmetic and timing:
- No wrap-around. count never decrements below 0 and never shows all-ones from an underflow.
- tc is exactly one cycle wide and is never asserted two consecutive cycles.
- Latency: with en held high after loading N (N>=1), tc is high in the cycle after the Nth enabled edge.
- Auto-reload period = N+1 enabled cycles (N decrements plus one reload cycle).
- auto_reload is sampled only at the count==1 and count==0 decision edges. Changing it mid-run only affects the next decision.

Test Plan:
1. Reset: hold rst 2 cycles with load=1, en=1 -> count=0, tc=0, busy=0, done=0, state IDLE.
2. One-shot:
   - Stimulus: load_val=5 with one load pulse, en=1, auto_reload=0.
   - Expect count 5,4,3,2,1,0; tc high exactly one cycle, coincident with count=0.
   - Then done=1, busy=0, count stays 0 for 10 more cycles (no wrap to 15).
3. Auto-reload: load_val=3, auto_reload=1, en=1 for 20 cycles -> count sequence 3,2,1,0,3,2,1,0,... with tc once per 4-cycle period; busy stays 1.
4. Enable gating:
   - Stimulus: load_val=4, toggle en 1,0,1,0,...
   - Expect count decrements only on en=1 edges; tc appears after the 4th enabled edge; count holds while en=0.
5. Load collisions:
   - Load 9 on the edge where count==1 and en=1 -> count=9, tc stays 0, busy=1.
   - Load 0 -> done=1 immediately, count=0, no tc.
6. Reset mid-run: load 7, run 3 cycles, assert rst for 1 cycle -> count=0, IDLE, tc=0; subsequent en=1 leaves count at 0 until the next load.
